// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store in flight, programmable latency,
// valid/ready on both request and response sides, misaligned/out-of-range error reporting.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_rdata_o,
   output logic        resp_error_o
);
   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t        r_state;
   logic [3:0]    r_cnt;
   logic          r_we;
   logic [1:0]    r_size;
   logic          r_uns;
   logic [AW+1:0] r_addr;
   logic [31:0]   r_wdata;
   logic          r_err;
   logic [31:0]   r_mem [DEPTH_WORDS];

   logic          w_err;
   logic          w_access;
   logic          w_store;
   logic [3:0]    w_be;
   logic [31:0]   w_wlanes;
   logic [31:0]   w_word;
   logic [7:0]    w_b;
   logic [15:0]   w_h;
   logic [31:0]   w_load;

   // Error is decided from the live request so the upper address bits need not be latched.
   always_comb begin
      w_err = 1'b0;
      case (req_size_i)
         2'b01:   w_err = req_addr_i[0];
         2'b10:   w_err = |req_addr_i[1:0];
         2'b11:   w_err = 1'b1;
         default: w_err = 1'b0;
      endcase
      if (req_addr_i[31:2] >= 30'(DEPTH_WORDS)) w_err = 1'b1;
   end

   assign req_ready_o = (r_state == S_IDLE) && !rst_i;
   assign w_access    = (r_state == S_WAIT) && (r_cnt == 4'd0);
   assign w_store     = w_access && r_we && !r_err;
   assign w_word      = r_mem[r_addr[AW+1:2]];

   always_comb begin
      w_be     = 4'hF;
      w_wlanes = r_wdata;
      case (r_size)
         2'b00: begin
            w_be     = 4'b0001 << r_addr[1:0];
            w_wlanes = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wlanes = {2{r_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      w_b = w_word[{r_addr[1:0], 3'b000} +: 8];
      w_h = r_addr[1] ? w_word[31:16] : w_word[15:0];
      case (r_size)
         2'b00:   w_load = {{24{~r_uns & w_b[7]}}, w_b};
         2'b01:   w_load = {{16{~r_uns & w_h[15]}}, w_h};
         default: w_load = w_word;
      endcase
   end

   // Array is intentionally unreset so contents survive a mid-operation reset.
   always_ff @(posedge clk_i) begin
      if (w_store) begin
         for (int i = 0; i < 4; i++)
            if (w_be[i]) r_mem[r_addr[AW+1:2]][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_we         <= 1'b0;
         r_size       <= 2'b00;
         r_uns        <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= 32'd0;
         r_err        <= 1'b0;
         resp_valid_o <= 1'b0;
         resp_rdata_o <= 32'd0;
         resp_error_o <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid_i) begin
                  r_we    <= req_we_i;
                  r_size  <= req_size_i;
                  r_uns   <= req_unsigned_i;
                  r_addr  <= req_addr_i[AW+1:0];
                  r_wdata <= req_wdata_i;
                  r_err   <= w_err;
                  r_cnt   <= 4'(LATENCY - 1);
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  resp_valid_o <= 1'b1;
                  resp_error_o <= r_err;
                  resp_rdata_o <= (r_err || r_we) ? 32'd0 : w_load;
                  r_state      <= S_RESP;
               end
            end
            S_RESP: begin
               if (resp_ready_i) begin
                  resp_valid_o <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
